// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with one-cycle fetch, fault reporting
// and a streaming program-load port (RUN -> LOAD -> FLUSH -> RUN).
module instr_mem_sync #(
  parameter int unsigned       WIDTH    = 32,
  parameter int unsigned       DEPTH    = 1024,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [WIDTH-1:0]  NOP_WORD = 32'hFC000000,
  parameter int unsigned       LEN_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_en,
  input  logic              stall,
  output logic [WIDTH-1:0]  command,
  output logic              command_valid,
  output logic              fault,
  input  logic              load_start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              load_done
);

  localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]  ptr;
  logic [LEN_W-1:0]  count, len, eff_len, count_inc;
  logic [ADDR_W-1:0] word_idx;
  logic              fetch_ok, write_en, last_word;

  always_comb begin
    eff_len   = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    word_idx  = pc >> 2;
    fetch_ok  = (pc[1:0] == 2'b00) && (word_idx < DEPTH_A);
    write_en  = (state == LOAD) && load_valid;
    count_inc = count + LEN_W'(1);
    last_word = write_en && (count_inc == len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (load_start && (eff_len != '0)) state_next = LOAD;
      LOAD:    if (last_word) state_next = FLUSH;
      FLUSH:   state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  assign load_ready = (state == LOAD);
  assign busy       = (state != RUN);

  // A zero-length load never leaves RUN but still reports completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      count     <= '0;
      len       <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= (state == FLUSH) ||
                   ((state == RUN) && load_start && (eff_len == '0));
      if ((state == RUN) && load_start) begin
        ptr   <= '0;
        count <= '0;
        len   <= eff_len;
      end else if (write_en) begin
        ptr   <= ptr + IDX_W'(1);
        count <= count_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[ptr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      command       <= NOP_WORD;
      command_valid <= 1'b0;
      fault         <= 1'b0;
    end else if ((state != RUN) || load_start) begin
      command_valid <= 1'b0;
    end else if (!stall) begin
      command_valid <= fetch_en;
      if (fetch_en) begin
        if (fetch_ok) begin
          command <= mem[word_idx[IDX_W-1:0]];
          fault   <= 1'b0;
        end else begin
          command <= NOP_WORD;
          fault   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Directed and randomized checks of instr_mem_sync against a word-level
// reference model (memory image plus expected fetch outputs).
`timescale 1ns/1ps
module tb_instr_mem_sync;

  localparam int          D     = 64;
  localparam int          IW    = $clog2(D);
  localparam int          LEN_W = $clog2(D) + 1;
  localparam logic [31:0] NOP   = 32'hFC000000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       pc;
  logic              fetch_en, stall;
  logic [31:0]       command;
  logic              command_valid, fault;
  logic              load_start;
  logic [LEN_W-1:0]  load_len;
  logic              load_valid;
  logic [31:0]       load_data;
  logic              load_ready, busy, load_done;

  instr_mem_sync #(.DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_en(fetch_en), .stall(stall),
    .command(command), .command_valid(command_valid), .fault(fault),
    .load_start(load_start), .load_len(load_len), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .busy(busy),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_mem [D];
  logic [31:0] exp_cmd;
  logic        exp_valid, exp_fault;
  logic [31:0] pend [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".command"}, command, exp_cmd);
    check({tag, ".valid"}, 32'(command_valid), 32'(exp_valid));
    check({tag, ".fault"}, 32'(fault), 32'(exp_fault));
  endtask

  task automatic model_fetch(input logic [31:0] a);
    if (a[1:0] != 2'b00 || (a >> 2) >= 32'(D)) begin
      exp_cmd   = NOP;
      exp_fault = 1'b1;
    end else begin
      exp_cmd   = model_mem[a[2 +: IW]];
      exp_fault = 1'b0;
    end
    exp_valid = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] a, input string tag);
    pc = a; fetch_en = 1'b1; stall = 1'b0;
    tick();
    model_fetch(a);
    check_outs(tag);
  endtask

  task automatic do_reset();
    #4 rst_n = 1'b0;
    #1;
    exp_cmd = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
    check_outs("reset");
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.load_ready", 32'(load_ready), 32'd0);
    check("reset.load_done", 32'(load_done), 32'd0);
    load_start = 1'b0; load_valid = 1'b0; fetch_en = 1'b0; stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_outs("post_reset");
  endtask

  task automatic do_load(input int n, input int gap_min, input int gap_max, input bit with_fetch);
    int eff, acc;
    logic [31:0] w;
    eff = (n > D) ? D : n;
    load_start = 1'b1; load_len = LEN_W'(n); load_valid = 1'b0;
    fetch_en = with_fetch; pc = '0; stall = 1'b0;
    tick();
    load_start = 1'b0; fetch_en = 1'b0;
    exp_valid = 1'b0;
    check_outs("load_start");
    if (eff == 0) begin
      check("len0.done", 32'(load_done), 32'd1);
      check("len0.busy", 32'(busy), 32'd0);
      tick();
      check("len0.done_clear", 32'(load_done), 32'd0);
      check("len0.busy2", 32'(busy), 32'd0);
      return;
    end
    check("load.busy", 32'(busy), 32'd1);
    check("load.ready", 32'(load_ready), 32'd1);
    acc = 0;
    while (acc < eff) begin
      repeat ($urandom_range(gap_min, gap_max)) begin
        load_valid = 1'b0;
        load_start = ($urandom_range(0, 7) == 0);
        fetch_en = $urandom_range(0, 1);
        pc = 32'($urandom_range(0, D - 1)) << 2;
        tick();
        check("gap.ready", 32'(load_ready), 32'd1);
        check_outs("gap");
      end
      if (pend.size() > 0) w = pend.pop_front();
      else w = $urandom;
      load_valid = 1'b1; load_data = w;
      load_start = ($urandom_range(0, 7) == 0);
      fetch_en = $urandom_range(0, 1);
      tick();
      model_mem[acc] = w;
      acc++;
      check("word.ready", 32'(load_ready), (acc < eff) ? 32'd1 : 32'd0);
      check("word.busy", 32'(busy), 32'd1);
      check("word.done", 32'(load_done), 32'd0);
      check_outs("word");
    end
    // stray data during FLUSH and the load_done cycle must not be stored
    load_start = 1'b0; fetch_en = 1'b0;
    load_valid = 1'b1; load_data = 32'hDEADBEEF;
    tick();
    check("flush.done", 32'(load_done), 32'd1);
    check("flush.busy", 32'(busy), 32'd0);
    check_outs("flush");
    tick();
    load_valid = 1'b0;
    check("done.clear", 32'(load_done), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int r;
    bit st, fe;
    rst_n = 1'b1; pc = '0; fetch_en = 1'b0; stall = 1'b0;
    load_start = 1'b0; load_len = '0; load_valid = 1'b0; load_data = '0;
    tick();
    do_reset();

    pend.push_back(32'h8C010000);
    pend.push_back(32'h8C020004);
    pend.push_back(32'h00221820);
    do_load(3, 0, 0, 1'b0);
    fetch(32'd0, "f0");
    check("f0.const", command, 32'h8C010000);
    fetch(32'd4, "f4");
    check("f4.const", command, 32'h8C020004);
    fetch(32'd8, "f8");
    check("f8.const", command, 32'h00221820);

    fetch(32'd2, "misaligned");
    fetch(32'(4 * D), "out_of_range");
    fetch(32'd0, "fault_clear");

    fetch(32'd4, "stall_pre");
    pc = 32'd8; stall = 1'b1;
    repeat (3) begin
      tick();
      check_outs("stall_hold");
    end
    stall = 1'b0;
    tick();
    model_fetch(32'd8);
    check_outs("stall_release");
    fetch_en = 1'b0;
    tick();
    exp_valid = 1'b0;
    check_outs("idle");

    do_load(0, 0, 0, 1'b0);
    do_load(D + 5, 0, 1, 1'b0);
    for (int i = 0; i < D; i += 13) fetch(32'(i * 4), "full_rb");
    fetch(32'(4 * (D - 1)), "last_word");

    do_load(6, 2, 2, 1'b0);
    for (int i = 0; i < 8; i++) fetch(32'(i * 4), "gap_rb");

    do_load(5, 0, 1, 1'b1);
    for (int i = 0; i < 5; i++) fetch(32'(i * 4), "coll_rb");

    load_start = 1'b1; load_len = LEN_W'(4); fetch_en = 1'b0;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      load_valid = 1'b1; load_data = a;
      tick();
      model_mem[i] = a;
    end
    load_valid = 1'b0;
    check("abort.busy", 32'(busy), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), "abort_rb");

    for (int c = 0; c < 300; c++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, D - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, D - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'(D + $urandom_range(0, 1000)) << 2;
      else             a = 32'hFFFFFFFC;
      fe = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 4) == 0);
      pc = a; fetch_en = fe; stall = st;
      tick();
      if (!st) begin
        if (fe) model_fetch(a);
        else    exp_valid = 1'b0;
      end
      check_outs("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Parametrised, synchronous-read instruction memory for the pipelined MIPS core, sitting between the PC register and the IF/ID register. It has these features:
- Byte-addressed, word-aligned fetch with one-cycle latency, a stall hold and misalignment/out-of-range fault reporting.
- A streaming program-load port with its own state machine, so test programs are written at run time instead of hard-coded.
- Faulting fetches return the core's NOP encoding, so the pipeline never consumes garbage.

## Interface
Parameters:
- WIDTH, 32: instruction word width in bits.
- DEPTH, 1024: number of instruction words stored.
- ADDR_W, 32: PC (byte address) width.
- NOP_WORD, 32'hFC000000: word returned on reset and on faulting fetches (opcode 6'b111111).
- LEN_W, $clog2(DEPTH)+1: width of the load length field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- pc  in  ADDR_W  byte address of the instruction to fetch.
- fetch_en  in  1  fetch request for pc this cycle.
- stall  in  1  hold all fetch outputs.
- command  out  WIDTH  fetched instruction (registered).
- command_valid  out  1  command holds a fetch result.
- fault  out  1  the last fetch was misaligned or out of range.
- load_start  in  1  begin a program load.
- load_len  in  LEN_W  number of words to load, sampled with load_start.
- load_valid  in  1  load_data is valid.
- load_data  in  WIDTH  instruction word to store.
- load_ready  out  1  block accepts load_data.
- busy  out  1  block is in the LOAD or FLUSH state.
- load_done  out  1  one-cycle pulse at the end of a load.

## Operation
- States: RUN, LOAD, FLUSH. Reset enters RUN.
- Reset applies these values:
  - command = NOP_WORD; command_valid = 0; fault = 0.
  - load_ready = 0; busy = 0; load_done = 0.
  - Write pointer = 0; load count = 0.
  - The memory array is not cleared.
- RUN fetch: word index = pc[ADDR_W-1:2]. On a clock edge where fetch_en=1 and stall=0:
  - If pc[1:0]!=0 or index>=DEPTH: command<=NOP_WORD, fault<=1, command_valid<=1.
  - Otherwise: command<=mem[index], fault<=0, command_valid<=1.
- RUN, fetch_en=0 and stall=0: command_valid<=0; command and fault hold.
- stall=1: command, command_valid and fault hold; this takes priority over fetch_en.
- RUN to LOAD: on load_start=1.
  - The effective length is min(load_len, DEPTH).
  - If the effective length is 0, the block pulses load_done next cycle and stays in RUN.
  - load_start overrides a fetch in the same cycle: command_valid<=0 and the fetch is dropped.
  - load_start is honoured even while stall=1.
- LOAD:
  - load_ready=1 and busy=1.
  - Each cycle with load_valid=1 writes mem[ptr]<=load_data and increments ptr and the count. The pointer starts at word 0.
  - When the count reaches the effective length, the block goes to FLUSH on the same edge as the last write.
  - fetch_en is ignored; command_valid=0.
  - load_start is ignored.
- FLUSH: lasts one cycle; load_ready=0, busy=1, command_valid=0. The next state is RUN, and load_done is 1 during the first RUN cycle.
- Reset mid-load: the load aborts, words already written remain, and the state returns to RUN.

## Timing
- Fetch latency: 1 cycle. pc is presented at edge N with fetch_en=1, and command/command_valid are valid after edge N.
- Load write: the word is stored at the edge where load_valid && load_ready. A fetch of that address is legal from the first RUN cycle after FLUSH.
- Throughput: 1 fetch per cycle in RUN; 1 load word per cycle in LOAD.
- Minimum RUN-to-RUN load time for L words: L + 2 cycles (LOAD cycles + FLUSH + load_done cycle).
- All outputs are registered; load_ready and busy decode directly from the state register.

## Test plan
- Reset: assert rst_n=0 mid-cycle -> immediately command=32'hFC000000, command_valid=0, fault=0, busy=0, load_ready=0.
- Load then fetch:
  - Stimulus: load_start with load_len=3, then stream 32'h8C010000, 32'h8C020004, 32'h00221820. Then fetch pc=0,4,8 back-to-back.
  - Required: load_done pulses once. The three words appear in order, one cycle after each pc, with command_valid=1 and fault=0.
- Faults: fetch pc=2 -> command=NOP_WORD, fault=1. Fetch pc=4*DEPTH -> NOP_WORD, fault=1. Fetch pc=0 -> fault=0.
- Stall:
  - Stimulus: fetch pc=4, then stall=1 for 3 cycles while pc=8.
  - Required: command stays 32'h8C020004 with command_valid=1; pc=8 is returned one cycle after stall drops.
- Load edge cases:
  - load_len=0 -> load_done the next cycle; busy never asserts.
  - load_len=DEPTH+5 -> exactly DEPTH words accepted, then FLUSH.
  - load_valid gaps of 2 cycles -> the pointer advances only on accepted words.
- Collision and abort:
  - load_start together with fetch_en -> command_valid=0 next cycle and busy=1.
  - rst_n pulse after 2 of 4 words -> state RUN, and words 0-1 are readable with the new values.
